// File: rtl/lsu.sv
// Load/store unit: accepts one load or store from the execution stage, runs it over a
// simple req/ack bus with a timeout, and formats load data for register writeback.
module lsu #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_load_en,
    input  logic [31:0] mem_load_addr,
    input  logic [4:0]  mem_load_regs_addr,
    input  logic        mem_store_en,
    input  logic [31:0] mem_store_addr,
    input  logic [31:0] mem_store_data,
    input  logic [2:0]  mem_funct3,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        regs_write_en,
    output logic [4:0]  regs_write_addr,
    output logic [31:0] regs_write_data,
    output logic        pause_signal,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       lat_offset;
    logic [2:0]       lat_funct3;
    logic [4:0]       lat_rd;
    logic             lat_load;

    logic        req_valid;
    logic        req_load;
    logic [31:0] req_addr;
    logic        req_misaligned;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        timeout;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    // A simultaneous load and store resolves in favour of the load.
    always_comb begin
        req_valid = mem_load_en | mem_store_en;
        req_load  = mem_load_en;
        req_addr  = mem_load_en ? mem_load_addr : mem_store_addr;
        case (mem_funct3[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            default: req_misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        req_wstrb = 4'b0000;
        req_wdata = 32'h0000_0000;
        if (!req_load) begin
            case (mem_funct3[1:0])
                2'b00: begin
                    req_wstrb = 4'b0001 << req_addr[1:0];
                    req_wdata = {4{mem_store_data[7:0]}};
                end
                2'b01: begin
                    req_wstrb = 4'b0011 << {req_addr[1], 1'b0};
                    req_wdata = {2{mem_store_data[15:0]}};
                end
                default: begin
                    req_wstrb = 4'b1111;
                    req_wdata = mem_store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (lat_offset)
            2'd0:    sel_byte = bus_rdata[7:0];
            2'd1:    sel_byte = bus_rdata[15:8];
            2'd2:    sel_byte = bus_rdata[23:16];
            default: sel_byte = bus_rdata[31:24];
        endcase
        sel_half = lat_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'h0, sel_byte};
            3'b101:  load_data = {16'h0, sel_half};
            default: load_data = bus_rdata;
        endcase
    end

    // An ack in the final counted cycle beats the timeout.
    always_comb begin
        next_state   = state;
        timeout      = 1'b0;
        pause_signal = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !req_misaligned) begin
                    pause_signal = 1'b1;
                    next_state   = BUS;
                end
            end
            BUS: begin
                timeout      = !bus_ack && (cycle_cnt == CNT_LAST);
                pause_signal = !(bus_ack && !lat_load) && !timeout;
                if (bus_ack) begin
                    next_state = lat_load ? WB : IDLE;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt       <= '0;
            lat_offset      <= 2'd0;
            lat_funct3      <= 3'd0;
            lat_rd          <= 5'd0;
            lat_load        <= 1'b0;
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            bus_addr        <= 32'h0;
            bus_wdata       <= 32'h0;
            bus_wstrb       <= 4'h0;
            regs_write_en   <= 1'b0;
            regs_write_addr <= 5'd0;
            regs_write_data <= 32'h0;
            misalign_err    <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            regs_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            bus_req    <= 1'b1;
                            bus_we     <= !req_load;
                            bus_addr   <= {req_addr[31:2], 2'b00};
                            bus_wdata  <= req_wdata;
                            bus_wstrb  <= req_wstrb;
                            lat_offset <= req_addr[1:0];
                            lat_funct3 <= mem_funct3;
                            lat_rd     <= mem_load_regs_addr;
                            lat_load   <= req_load;
                            cycle_cnt  <= '0;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (lat_load) begin
                            regs_write_en   <= (lat_rd != 5'd0);
                            regs_write_addr <= lat_rd;
                            regs_write_data <= load_data;
                        end
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a table of directed transactions, randomized transactions
// scored by a byte-lane reference model, and hand sequences for reset and back-to-back cases.
module tb_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_load_en;
    logic [31:0] mem_load_addr;
    logic [4:0]  mem_load_regs_addr;
    logic        mem_store_en;
    logic [31:0] mem_store_addr;
    logic [31:0] mem_store_data;
    logic [2:0]  mem_funct3;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;
    logic        pause_signal;
    logic        misalign_err;
    logic        bus_err;

    int tests_run    = 0;
    int tests_failed = 0;

    lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_load_en        (mem_load_en),
        .mem_load_addr      (mem_load_addr),
        .mem_load_regs_addr (mem_load_regs_addr),
        .mem_store_en       (mem_store_en),
        .mem_store_addr     (mem_store_addr),
        .mem_store_data     (mem_store_data),
        .mem_funct3         (mem_funct3),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_wstrb          (bus_wstrb),
        .bus_ack            (bus_ack),
        .bus_rdata          (bus_rdata),
        .regs_write_en      (regs_write_en),
        .regs_write_addr    (regs_write_addr),
        .regs_write_data    (regs_write_data),
        .pause_signal       (pause_signal),
        .misalign_err       (misalign_err),
        .bus_err            (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_req_cycles;
        logic        exp_we;
        logic [31:0] exp_bus_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        int          exp_wb_cnt;
        logic [31:0] exp_wb_data;
        int          exp_mis;
        int          exp_berr;
        logic        exp_pause_accept;
        logic        exp_pause_last;
    } vec_t;

    typedef struct {
        int          req_cycles;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        stable;
        int          wb_cnt;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        int          mis_cnt;
        int          berr_cnt;
        logic        pause_accept;
        logic        pause_last;
        logic        pause_mid_ok;
    } obs_t;

    function automatic vec_t mk(input logic is_load, input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] f3, input logic [4:0] rd, input int ack_at,
                                input logic [31:0] rdata, input int exp_req, input logic [3:0] exp_wstrb,
                                input logic [31:0] exp_wdata, input int exp_wb_cnt,
                                input logic [31:0] exp_wb_data, input int exp_mis, input int exp_berr,
                                input logic exp_pause_last);
        vec_t v;
        v.is_load          = is_load;
        v.addr             = addr;
        v.data             = data;
        v.funct3           = f3;
        v.rd               = rd;
        v.ack_at           = ack_at;
        v.rdata            = rdata;
        v.exp_req_cycles   = exp_req;
        v.exp_we           = !is_load;
        v.exp_bus_addr     = addr & ~32'h3;
        v.exp_wstrb        = exp_wstrb;
        v.exp_wdata        = exp_wdata;
        v.exp_wb_cnt       = exp_wb_cnt;
        v.exp_wb_data      = exp_wb_data;
        v.exp_mis          = exp_mis;
        v.exp_berr         = exp_berr;
        v.exp_pause_accept = (exp_mis == 0);
        v.exp_pause_last   = exp_pause_last;
        return v;
    endfunction

    // Reference model: lane positions and extension worked out arithmetically from the offset.
    function automatic vec_t model(input logic is_load, input logic [31:0] addr, input logic [31:0] data,
                                   input logic [2:0] f3, input logic [4:0] rd, input int ack_at,
                                   input logic [31:0] rdata);
        vec_t   v;
        int     size;
        int     off;
        int     width;
        bit     mis;
        bit     tmo;
        longint field;
        size = int'(f3[1:0]);
        off  = int'(addr % 4);
        mis  = (size == 1 && off % 2 != 0) || (size == 2 && off != 0);
        tmo  = (ack_at < 1) || (ack_at > TMO);
        v.is_load        = is_load;
        v.addr           = addr;
        v.data           = data;
        v.funct3         = f3;
        v.rd             = rd;
        v.ack_at         = ack_at;
        v.rdata          = rdata;
        v.exp_we         = !is_load;
        v.exp_bus_addr   = addr - 32'(off);
        v.exp_req_cycles = mis ? 0 : (tmo ? TMO : ack_at);
        if (is_load) begin
            v.exp_wstrb = 4'h0;
            v.exp_wdata = 32'h0;
        end else if (size == 0) begin
            v.exp_wstrb = 4'(1 << off);
            v.exp_wdata = (data % 256) * 32'h0101_0101;
        end else if (size == 1) begin
            v.exp_wstrb = 4'(3 << (off - off % 2));
            v.exp_wdata = (data % 65536) * 32'h0001_0001;
        end else begin
            v.exp_wstrb = 4'hF;
            v.exp_wdata = data;
        end
        field = longint'({32'd0, rdata});
        if (size != 2) begin
            width = (size == 0) ? 8 : 16;
            field = (field >> (8 * off)) % (longint'(1) << width);
            if (!f3[2] && field >= (longint'(1) << (width - 1))) field = field - (longint'(1) << width);
        end
        v.exp_wb_data      = 32'(field);
        v.exp_wb_cnt       = (is_load && !mis && !tmo && rd != 5'd0) ? 1 : 0;
        v.exp_mis          = mis ? 1 : 0;
        v.exp_berr         = (!mis && tmo) ? 1 : 0;
        v.exp_pause_accept = !mis;
        v.exp_pause_last   = is_load && !tmo;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request for a single cycle, plays the bus slave, and records what the DUT did.
    task automatic applyStimulus(input vec_t v, output obs_t o);
        logic prev_pause;
        logic seen_req;
        o.req_cycles = 0;  o.we = 1'b0;    o.addr = '0;      o.wstrb = '0;
        o.wdata = '0;      o.stable = 1'b1; o.wb_cnt = 0;     o.wb_addr = '0;
        o.wb_data = '0;    o.mis_cnt = 0;   o.berr_cnt = 0;   o.pause_last = 1'b0;
        o.pause_mid_ok = 1'b1;
        prev_pause = 1'b0;
        seen_req   = 1'b0;
        mem_load_en        = v.is_load;
        mem_store_en       = !v.is_load;
        mem_load_addr      = v.addr;
        mem_store_addr     = v.addr;
        mem_store_data     = v.data;
        mem_funct3         = v.funct3;
        mem_load_regs_addr = v.rd;
        #1;
        o.pause_accept = pause_signal;
        @(posedge clk); #1;
        mem_load_en  = 1'b0;
        mem_store_en = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            bus_ack = 1'b0;
            if (bus_req) begin
                o.req_cycles++;
                if (o.req_cycles == 1) begin
                    o.we    = bus_we;
                    o.addr  = bus_addr;
                    o.wstrb = bus_wstrb;
                    o.wdata = bus_wdata;
                end else if (bus_we !== o.we || bus_addr !== o.addr ||
                             bus_wstrb !== o.wstrb || bus_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                if (cyc == v.ack_at) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.rdata;
                end
            end
            #1;
            if (bus_req) begin
                if (seen_req && !prev_pause) o.pause_mid_ok = 1'b0;
                prev_pause = pause_signal;
                seen_req   = 1'b1;
            end
            if (misalign_err) o.mis_cnt++;
            if (bus_err) o.berr_cnt++;
            if (regs_write_en) begin
                o.wb_cnt++;
                o.wb_addr = regs_write_addr;
                o.wb_data = regs_write_data;
            end
            @(posedge clk); #1;
        end
        bus_ack      = 1'b0;
        o.pause_last = prev_pause;
    endtask

    task automatic checkOutput(input vec_t v, input obs_t o, input string tag);
        checkValue({tag, ".req_cycles"}, o.req_cycles, v.exp_req_cycles);
        checkValue({tag, ".pause_accept"}, o.pause_accept, v.exp_pause_accept);
        checkValue({tag, ".misalign_err"}, o.mis_cnt, v.exp_mis);
        checkValue({tag, ".bus_err"}, o.berr_cnt, v.exp_berr);
        checkValue({tag, ".wb_count"}, o.wb_cnt, v.exp_wb_cnt);
        if (v.exp_req_cycles > 0) begin
            checkValue({tag, ".bus_we"}, o.we, v.exp_we);
            checkValue({tag, ".bus_addr"}, o.addr, v.exp_bus_addr);
            checkValue({tag, ".bus_wstrb"}, o.wstrb, v.exp_wstrb);
            checkValue({tag, ".bus_stable"}, o.stable, 1);
            checkValue({tag, ".pause_last"}, o.pause_last, v.exp_pause_last);
            checkValue({tag, ".pause_mid"}, o.pause_mid_ok, 1);
            if (!v.is_load) checkValue({tag, ".bus_wdata"}, o.wdata, v.exp_wdata);
        end
        if (v.exp_wb_cnt > 0) begin
            checkValue({tag, ".wb_addr"}, o.wb_addr, v.rd);
            checkValue({tag, ".wb_data"}, o.wb_data, v.exp_wb_data);
        end
    endtask

    initial begin
        vec_t vecs[13];
        vec_t v;
        obs_t o;
        int   wb_seen;
        logic [2:0] f3;
        logic       ld;

        vecs[0]  = mk(0, 32'h104, 32'hDEADBEEF, 3'b010, 0, 3, 0, 3, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h203, 0, 3'b000, 5, 2, 32'h80FFFFFF, 2, 4'b0000, 0, 1, 32'hFFFFFF80, 0, 0, 1);
        vecs[2]  = mk(1, 32'h203, 0, 3'b100, 5, 2, 32'h80FFFFFF, 2, 4'b0000, 0, 1, 32'h00000080, 0, 0, 1);
        vecs[3]  = mk(0, 32'h302, 32'h0000ABCD, 3'b001, 0, 1, 0, 1, 4'b1100, 32'hABCDABCD, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 32'h101, 0, 3'b010, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(1, 32'h400, 0, 3'b010, 8, 0, 0, 4, 4'b0000, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(1, 32'h400, 0, 3'b010, 7, 4, 32'h12345678, 4, 4'b0000, 0, 1, 32'h12345678, 0, 0, 1);
        vecs[7]  = mk(1, 32'h206, 0, 3'b001, 3, 1, 32'h80017FFF, 1, 4'b0000, 0, 1, 32'hFFFF8001, 0, 0, 1);
        vecs[8]  = mk(1, 32'h204, 0, 3'b101, 3, 1, 32'h80017FFF, 1, 4'b0000, 0, 1, 32'h00007FFF, 0, 0, 1);
        vecs[9]  = mk(1, 32'h010, 0, 3'b010, 0, 1, 32'hAAAA5555, 1, 4'b0000, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(0, 32'h011, 32'h123456A5, 3'b000, 0, 2, 0, 2, 4'b0010, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 32'h013, 0, 3'b001, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0);
        vecs[12] = mk(1, 32'h200, 0, 3'b000, 2, 1, 32'h80FFFF7F, 1, 4'b0000, 0, 1, 32'h0000007F, 0, 0, 1);

        rst = 1'b1;
        mem_load_en = 1'b0;  mem_load_addr = '0;  mem_load_regs_addr = '0;
        mem_store_en = 1'b0; mem_store_addr = '0; mem_store_data = '0;
        mem_funct3 = '0;     bus_ack = 1'b0;      bus_rdata = '0;

        #12;
        checkValue("reset.bus_req", bus_req, 0);
        checkValue("reset.bus_we", bus_we, 0);
        checkValue("reset.bus_addr", bus_addr, 0);
        checkValue("reset.bus_wdata", bus_wdata, 0);
        checkValue("reset.bus_wstrb", bus_wstrb, 0);
        checkValue("reset.regs_write_en", regs_write_en, 0);
        checkValue("reset.regs_write_addr", regs_write_addr, 0);
        checkValue("reset.regs_write_data", regs_write_data, 0);
        checkValue("reset.misalign_err", misalign_err, 0);
        checkValue("reset.bus_err", bus_err, 0);
        checkValue("reset.pause", pause_signal, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], o);
            checkOutput(vecs[i], o, $sformatf("vec%0d", i));
        end

        // Load and store together: the load is the one that goes out.
        mem_load_en = 1'b1;  mem_load_addr = 32'h600; mem_load_regs_addr = 5'd4;
        mem_store_en = 1'b1; mem_store_addr = 32'h700; mem_store_data = 32'h55;
        mem_funct3 = 3'b010;
        #1;
        checkValue("both.pause", pause_signal, 1);
        @(posedge clk); #1;
        mem_load_en = 1'b0; mem_store_en = 1'b0;
        checkValue("both.bus_we", bus_we, 0);
        checkValue("both.bus_addr", bus_addr, 32'h600);
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkValue("both.wb_en", regs_write_en, 1);
        checkValue("both.wb_data", regs_write_data, 32'h0BADF00D);
        @(posedge clk); #1;

        // Back-to-back: requests right after a store ack and right after WB are taken at once.
        mem_store_en = 1'b1; mem_store_addr = 32'h800; mem_store_data = 32'h11223344;
        mem_funct3 = 3'b010;
        @(posedge clk); #1;
        mem_store_en = 1'b0;
        checkValue("b2b.store_req", bus_req, 1);
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkValue("b2b.store_done", bus_req, 0);
        mem_load_en = 1'b1; mem_load_addr = 32'h804; mem_load_regs_addr = 5'd6;
        #1;
        checkValue("b2b.pause_idle", pause_signal, 1);
        @(posedge clk); #1;
        mem_load_en = 1'b0;
        checkValue("b2b.load_req", bus_req, 1);
        checkValue("b2b.load_addr", bus_addr, 32'h804);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkValue("b2b.wb_en", regs_write_en, 1);
        checkValue("b2b.wb_data", regs_write_data, 32'hCAFEF00D);
        checkValue("b2b.pause_wb", pause_signal, 0);
        @(posedge clk); #1;
        checkValue("b2b.wb_once", regs_write_en, 0);
        mem_store_en = 1'b1; mem_store_addr = 32'h808;
        @(posedge clk); #1;
        mem_store_en = 1'b0;
        checkValue("b2b.store2_req", bus_req, 1);
        checkValue("b2b.store2_we", bus_we, 1);
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a load, then a stale ack.
        mem_load_en = 1'b1; mem_load_addr = 32'h500; mem_load_regs_addr = 5'd9;
        mem_funct3 = 3'b010;
        @(posedge clk); #1;
        mem_load_en = 1'b0;
        checkValue("rst.req_before", bus_req, 1);
        #2 rst = 1'b1;
        #1;
        checkValue("rst.req_async", bus_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h77777777;
        wb_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (regs_write_en) wb_seen++;
        end
        checkValue("rst.no_wb", wb_seen, 0);
        checkValue("rst.req_after", bus_req, 0);

        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom_range(0, 1));
            if (ld) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            v = model(ld, $urandom, $urandom, f3, 5'($urandom_range(0, 31)),
                      int'($urandom_range(0, 5)), $urandom);
            applyStimulus(v, o);
            checkOutput(v, o, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum number of cycles spent in BUS before the request is aborted.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_load_en  input  1  load request from execution stage.
REQ-005 SHALL have port mem_load_addr  input  32  load byte address.
REQ-006 SHALL have port mem_load_regs_addr  input  5  load destination register.
REQ-007 SHALL have port mem_store_en  input  1  store request.
REQ-008 SHALL have port mem_store_addr  input  32  store byte address.
REQ-009 SHALL have port mem_store_data  input  32  store data, unaligned (value in low lanes).
REQ-010 SHALL have port mem_funct3  input  3  access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-011 SHALL have port bus_req  output  1  bus request, held until ack.
REQ-012 SHALL have port bus_we  output  1  1 = write.
REQ-013 SHALL have port bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 SHALL have port bus_wdata  output  32  lane-replicated write data.
REQ-015 SHALL have port bus_wstrb  output  4  byte write strobes.
REQ-016 SHALL have port bus_ack  input  1  bus completion, one cycle.
REQ-017 SHALL have port bus_rdata  input  32  read word, valid when bus_ack high.
REQ-018 SHALL have port regs_write_en  output  1  load writeback enable.
REQ-019 SHALL have port regs_write_addr  output  5  writeback register.
REQ-020 SHALL have port regs_write_data  output  32  formatted load data.
REQ-021 SHALL have port pause_signal  output  1  combinational stall to upstream stages.
REQ-022 SHALL have port misalign_err  output  1  one-cycle pulse, misaligned request dropped.
REQ-023 SHALL have port bus_err  output  1  one-cycle pulse, timeout abort.

Function
REQ-024 SHALL implement the states IDLE, BUS and WB; requests SHALL be sampled only in IDLE and ignored otherwise.
REQ-025 In IDLE, when load_en or store_en is high, the block SHALL latch the address, data, funct3, rd and direction, and move to BUS; if both are high, the load SHALL win and the store SHALL be dropped.
REQ-026 SHALL treat a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, as misaligned: misalign_err pulses in the next cycle, no bus access occurs, and the state stays IDLE.
REQ-027 SHALL register the bus outputs: bus_req rises the cycle after acceptance, and bus_we/addr/wdata/wstrb SHALL stay stable while bus_req is high.
REQ-028 Store strobes SHALL be: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}; SW = 4'b1111. Write data SHALL be replicated to every byte (SB) or halfword (SH) lane. Loads SHALL drive wstrb=0.
REQ-029 In BUS, on bus_ack: bus_req SHALL drop the next cycle; a store SHALL go to IDLE; a load SHALL capture the formatted bus_rdata and go to WB.
REQ-030 Load formatting SHALL select the byte by addr[1:0] or the halfword by addr[1]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-031 In WB, regs_write_en SHALL be high for exactly one cycle with the captured rd and data, then the state returns to IDLE; when rd=0, regs_write_en SHALL stay 0.
REQ-032 SHALL clear an 8-bit-minimum cycle counter on entry to BUS and increment it each BUS cycle without ack.
REQ-033 When the counter equals TIMEOUT_CYCLES-1 and there is no ack, the block SHALL drop bus_req, pulse bus_err the next cycle, discard the access and go to IDLE.
REQ-034 An ack arriving in the same cycle as the timeout SHALL win.
REQ-035 pause_signal SHALL be high when (IDLE and an aligned request is present) or (BUS and not (bus_ack with a store) and not timeout); it SHALL be low in WB, in IDLE with no request, and for misaligned requests.
REQ-036 Back-to-back operation: a request present in the cycle after a store ack or after WB SHALL be accepted immediately.

Reset
REQ-037 When rst is high, the state SHALL become IDLE and the counter 0; bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, regs_write_en, regs_write_addr, regs_write_data, misalign_err and bus_err SHALL all be 0, asynchronously.
REQ-038 A reset mid-transaction SHALL abandon the access with no writeback, and a late bus_ack after reset SHALL be ignored.

Verification
REQ-039 SW addr 0x104, data 0xDEADBEEF, ack 3 cycles later -> bus_req high for 3 cycles, addr 0x104, wstrb 1111; pause low on the ack cycle.
REQ-040 LB addr 0x203, rd=5, rdata 0x80FFFFFF -> WB writes x5 = 0xFFFFFF80; LBU with the same inputs -> 0x00000080.
REQ-041 SH addr 0x302, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD.
REQ-042 LW addr 0x101 -> misalign_err pulse, bus_req never rises, pause low.
REQ-043 LW with no ack and TIMEOUT_CYCLES=4 -> bus_req high for 4 cycles, bus_err pulse, no writeback; ack on the 4th cycle instead -> normal writeback.
REQ-044 rst asserted during BUS -> bus_req 0 immediately; a subsequent ack produces no regs_write_en.
